// File: rtl/apb_initiator.sv
// APB requester: turns single cmd_* requests into APB SETUP/ACCESS transfers
// and reports completion, slave error or wait-state timeout on a registered rsp_* pulse.
module apb_initiator #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_sel,
  input  logic [19:0] cmd_addr,
  input  logic [15:0] cmd_wdata,
  input  logic [1:0]  cmd_strb,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic [1:0]  psel,
  output logic        penable,
  output logic [19:0] paddr,
  output logic [15:0] pwdata,
  output logic        pwrite,
  output logic [1:0]  pstrb,
  input  logic [15:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  logic [1:0] state;
  logic [7:0] wait_cnt;
  logic       sel_q;
  logic       xfer_done;
  logic       xfer_abort;

  assign cmd_ready  = (state == IDLE);
  assign penable    = (state == ACCESS);
  assign psel       = (state == IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign xfer_done  = (state == ACCESS) && pready;
  assign xfer_abort = (state == ACCESS) && !pready && (wait_cnt == WAIT_LAST);

  // Address/data registers double as the APB outputs so they hold in IDLE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wait_cnt <= 8'd0;
      sel_q    <= 1'b0;
      paddr    <= 20'd0;
      pwdata   <= 16'd0;
      pwrite   <= 1'b0;
      pstrb    <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            sel_q  <= cmd_sel;
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            pwdata <= cmd_write ? cmd_wdata : 16'd0;
            pstrb  <= cmd_write ? cmd_strb : 2'b00;
            state  <= SETUP;
          end
        end
        SETUP: begin
          wait_cnt <= 8'd0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done || xfer_abort) begin
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Response fields only change on a completion or abort, so they hold between pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 16'd0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      rsp_valid <= xfer_done || xfer_abort;
      if (xfer_done) begin
        rsp_rdata   <= pwrite ? 16'd0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (xfer_abort) begin
        rsp_rdata   <= 16'd0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized bench for apb_initiator: a transaction-level responder decides each
// transfer's wait count and response, and expectations follow from those choices.
module tb_apb_initiator;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic        cmd_sel = 1'b0;
  logic [19:0] cmd_addr = '0;
  logic [15:0] cmd_wdata = '0;
  logic [1:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  psel;
  logic        penable;
  logic [19:0] paddr;
  logic [15:0] pwdata;
  logic        pwrite;
  logic [1:0]  pstrb;
  logic [15:0] prdata = '0;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;

  int checks = 0;
  int failures = 0;

  int          obs_access;
  int          obs_proto_err;
  logic        obs_ready_at_accept;
  logic        obs_rsp_valid;
  logic [15:0] obs_rdata;
  logic        obs_err;
  logic        obs_to;
  logic        obs_ready_after;
  logic [1:0]  obs_psel_after;

  apb_initiator #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .psel(psel), .penable(penable), .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite), .pstrb(pstrb),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 clk = ~clk;

  // Drives one command from an IDLE negedge and plays a responder that raises
  // pready after 'waits' stalled ACCESS cycles; records what it saw for the caller.
  task automatic do_transfer(input logic wr, input logic sel, input logic [19:0] addr,
                             input logic [15:0] wdata, input logic [1:0] strb, input int waits,
                             input logic slverr, input logic [15:0] rdata, input logic keep_valid);
    logic [1:0]  exp_psel;
    logic [15:0] exp_pwdata;
    logic [1:0]  exp_pstrb;
    int n;
    exp_psel   = sel ? 2'b10 : 2'b01;
    exp_pwdata = wr ? wdata : 16'd0;
    exp_pstrb  = wr ? strb : 2'b00;
    obs_proto_err = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_sel = sel; cmd_addr = addr;
    cmd_wdata = wdata; cmd_strb = strb;
    obs_ready_at_accept = cmd_ready;
    @(negedge clk);
    if (psel !== exp_psel || penable !== 1'b0 || paddr !== addr || pwrite !== wr ||
        pwdata !== exp_pwdata || pstrb !== exp_pstrb || cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
      obs_proto_err++;
    if (keep_valid) begin
      cmd_write = 1'($urandom()); cmd_sel = 1'($urandom()); cmd_addr = 20'($urandom());
      cmd_wdata = 16'($urandom()); cmd_strb = 2'($urandom());
    end else begin
      cmd_valid = 1'b0;
    end
    pready = 1'b0; pslverr = 1'($urandom()); prdata = 16'($urandom());
    @(negedge clk);
    n = 0;
    while (penable === 1'b1 && n < 300) begin
      if (psel !== exp_psel || paddr !== addr || pwrite !== wr || pwdata !== exp_pwdata ||
          pstrb !== exp_pstrb || cmd_ready !== 1'b0 || rsp_valid !== 1'b0)
        obs_proto_err++;
      pready  = (n == waits);
      pslverr = pready ? slverr : 1'($urandom());
      prdata  = pready ? rdata : 16'($urandom());
      if (keep_valid) begin
        cmd_write = 1'($urandom()); cmd_sel = 1'($urandom()); cmd_addr = 20'($urandom());
        cmd_wdata = 16'($urandom()); cmd_strb = 2'($urandom());
      end
      @(negedge clk);
      n++;
    end
    pready = 1'b0; pslverr = 1'b0; prdata = 16'd0;
    if (paddr !== addr || pwrite !== wr || pwdata !== exp_pwdata || pstrb !== exp_pstrb || penable !== 1'b0)
      obs_proto_err++;
    obs_access      = n;
    obs_rsp_valid   = rsp_valid;
    obs_rdata       = rsp_rdata;
    obs_err         = rsp_err;
    obs_to          = rsp_timeout;
    obs_ready_after = cmd_ready;
    obs_psel_after  = psel;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (psel !== 2'b00 || penable !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_apb_ctrl: psel=%b penable=%b expected 00/0", psel, penable);
    end
    checks++;
    if (paddr !== 20'd0 || pwdata !== 16'd0 || pwrite !== 1'b0 || pstrb !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_apb_data: paddr=%h pwdata=%h pwrite=%b pstrb=%b expected zeros", paddr, pwdata, pwrite, pstrb);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'd0 || rsp_err !== 1'b0 || rsp_timeout !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_rsp: valid=%b rdata=%h err=%b to=%b expected zeros", rsp_valid, rsp_rdata, rsp_err, rsp_timeout);
    end
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 2'b00) begin
      failures++; $display("[TB] FAIL reset_idle: cmd_ready=%b psel=%b expected 1/00", cmd_ready, psel);
    end
  endtask

  task automatic test_basic_read();
    do_transfer(1'b0, 1'b0, 20'h00123, 16'hFFFF, 2'b11, 0, 1'b0, 16'hABCD, 1'b0);
    checks++;
    if (obs_ready_at_accept !== 1'b1) begin
      failures++; $display("[TB] FAIL read_ready: got %b expected 1", obs_ready_at_accept);
    end
    checks++;
    if (obs_access != 1) begin
      failures++; $display("[TB] FAIL read_access_cycles: got %0d expected 1", obs_access);
    end
    checks++;
    if (obs_proto_err != 0) begin
      failures++; $display("[TB] FAIL read_protocol: got %0d violations expected 0", obs_proto_err);
    end
    checks++;
    if (obs_rsp_valid !== 1'b1 || obs_rdata !== 16'hABCD || obs_err !== 1'b0 || obs_to !== 1'b0) begin
      failures++; $display("[TB] FAIL read_rsp: valid=%b rdata=%h err=%b to=%b expected 1/abcd/0/0", obs_rsp_valid, obs_rdata, obs_err, obs_to);
    end
    checks++;
    if (obs_ready_after !== 1'b1 || obs_psel_after !== 2'b00) begin
      failures++; $display("[TB] FAIL read_idle_after: cmd_ready=%b psel=%b expected 1/00", obs_ready_after, obs_psel_after);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 16'hABCD) begin
      failures++; $display("[TB] FAIL read_rsp_hold: valid=%b rdata=%h expected 0/abcd", rsp_valid, rsp_rdata);
    end
  endtask

  task automatic test_write_wait();
    do_transfer(1'b1, 1'b1, 20'hF0A5C, 16'h5A5A, 2'b10, 3, 1'b0, 16'h1234, 1'b0);
    checks++;
    if (obs_access != 4) begin
      failures++; $display("[TB] FAIL write_access_cycles: got %0d expected 4", obs_access);
    end
    checks++;
    if (obs_proto_err != 0) begin
      failures++; $display("[TB] FAIL write_stability: got %0d violations expected 0", obs_proto_err);
    end
    checks++;
    if (obs_rsp_valid !== 1'b1 || obs_rdata !== 16'd0 || obs_err !== 1'b0 || obs_to !== 1'b0) begin
      failures++; $display("[TB] FAIL write_rsp: valid=%b rdata=%h err=%b to=%b expected 1/0000/0/0", obs_rsp_valid, obs_rdata, obs_err, obs_to);
    end
  endtask

  task automatic test_slverr();
    do_transfer(1'b0, 1'b1, 20'h0BEEF, 16'h0, 2'b00, 2, 1'b1, 16'hC0DE, 1'b0);
    checks++;
    if (obs_rsp_valid !== 1'b1 || obs_rdata !== 16'hC0DE || obs_err !== 1'b1 || obs_to !== 1'b0) begin
      failures++; $display("[TB] FAIL slverr_rsp: valid=%b rdata=%h err=%b to=%b expected 1/c0de/1/0", obs_rsp_valid, obs_rdata, obs_err, obs_to);
    end
    do_transfer(1'b0, 1'b0, 20'h00042, 16'h0, 2'b00, 6, 1'b0, 16'h7777, 1'b0);
    checks++;
    if (obs_access != 7 || obs_err !== 1'b0 || obs_rdata !== 16'h7777) begin
      failures++; $display("[TB] FAIL slverr_ignored_when_waiting: cycles=%0d err=%b rdata=%h expected 7/0/7777", obs_access, obs_err, obs_rdata);
    end
  endtask

  task automatic test_timeout();
    do_transfer(1'b0, 1'b0, 20'h11111, 16'h0, 2'b00, 1000, 1'b0, 16'hFFFF, 1'b0);
    checks++;
    if (obs_access != TIMEOUT) begin
      failures++; $display("[TB] FAIL timeout_cycles: got %0d expected %0d", obs_access, TIMEOUT);
    end
    checks++;
    if (obs_rsp_valid !== 1'b1 || obs_rdata !== 16'd0 || obs_err !== 1'b1 || obs_to !== 1'b1) begin
      failures++; $display("[TB] FAIL timeout_rsp: valid=%b rdata=%h err=%b to=%b expected 1/0000/1/1", obs_rsp_valid, obs_rdata, obs_err, obs_to);
    end
    do_transfer(1'b0, 1'b1, 20'h22222, 16'h0, 2'b00, TIMEOUT - 1, 1'b0, 16'h3C3C, 1'b0);
    checks++;
    if (obs_access != TIMEOUT || obs_to !== 1'b0 || obs_err !== 1'b0 || obs_rdata !== 16'h3C3C) begin
      failures++; $display("[TB] FAIL timeout_last_cycle_ready: cycles=%0d to=%b err=%b rdata=%h expected %0d/0/0/3c3c", obs_access, obs_to, obs_err, obs_rdata, TIMEOUT);
    end
  endtask

  task automatic test_random();
    logic        wr, sel, slverr, exp_to, exp_err;
    logic [19:0] addr;
    logic [15:0] wdata, rdata, exp_rdata;
    logic [1:0]  strb;
    int waits, exp_n, resp_count;
    resp_count = 0;
    for (int i = 0; i < 1000; i++) begin
      wr = 1'($urandom()); sel = 1'($urandom()); addr = 20'($urandom());
      wdata = 16'($urandom()); strb = 2'($urandom()); slverr = 1'($urandom());
      rdata = 16'($urandom()); waits = int'($urandom_range(0, 20));
      do_transfer(wr, sel, addr, wdata, strb, waits, slverr, rdata, 1'b1);
      exp_to    = (waits >= TIMEOUT);
      exp_n     = exp_to ? TIMEOUT : waits + 1;
      exp_err   = exp_to | slverr;
      exp_rdata = (exp_to || wr) ? 16'd0 : rdata;
      if (obs_rsp_valid === 1'b1) resp_count++;
      checks++;
      if (obs_access != exp_n || obs_proto_err != 0 || obs_ready_at_accept !== 1'b1) begin
        failures++; $display("[TB] FAIL rand_protocol[%0d]: cycles=%0d violations=%0d ready=%b expected %0d/0/1", i, obs_access, obs_proto_err, obs_ready_at_accept, exp_n);
      end
      checks++;
      if (obs_rsp_valid !== 1'b1 || obs_rdata !== exp_rdata || obs_err !== exp_err || obs_to !== exp_to) begin
        failures++; $display("[TB] FAIL rand_rsp[%0d]: valid=%b rdata=%h err=%b to=%b expected 1/%h/%b/%b", i, obs_rsp_valid, obs_rdata, obs_err, obs_to, exp_rdata, exp_err, exp_to);
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (resp_count != 1000) begin
      failures++; $display("[TB] FAIL rand_resp_count: got %0d expected 1000", resp_count);
    end
  endtask

  task automatic test_reset_mid();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_sel = 1'b1; cmd_addr = 20'hAAAAA;
    cmd_wdata = 16'h9999; cmd_strb = 2'b11;
    @(negedge clk);
    cmd_valid = 1'b0; pready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (penable !== 1'b1 || psel !== 2'b10) begin
      failures++; $display("[TB] FAIL midreset_in_access: psel=%b penable=%b expected 10/1", psel, penable);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (psel !== 2'b00 || penable !== 1'b0 || rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_async_drop: psel=%b penable=%b rsp_valid=%b expected 00/0/0", psel, penable, rsp_valid);
    end
    cmd_valid = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (psel !== 2'b00 || rsp_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL midreset_no_accept: psel=%b rsp_valid=%b expected 00/0", psel, rsp_valid);
    end
    cmd_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (psel !== 2'b00 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++; $display("[TB] FAIL midreset_release: psel=%b rsp_valid=%b cmd_ready=%b expected 00/0/1", psel, rsp_valid, cmd_ready);
    end
    do_transfer(1'b0, 1'b0, 20'h00777, 16'h0, 2'b00, 1, 1'b0, 16'h2468, 1'b0);
    checks++;
    if (obs_access != 2 || obs_proto_err != 0 || obs_rsp_valid !== 1'b1 || obs_rdata !== 16'h2468) begin
      failures++; $display("[TB] FAIL midreset_next_cmd: cycles=%0d violations=%0d valid=%b rdata=%h expected 2/0/1/2468", obs_access, obs_proto_err, obs_rsp_valid, obs_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_basic_read();
    test_write_wait();
    test_slverr();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
